// File: rtl/ser_frame_rx.sv
// Serial-to-parallel frame receiver: reassembles WIDTH-bit words delimited by a
// one-cycle sload marker, with a valid strobe, frame counter and sticky framing error.
module ser_frame_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             serclk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             sload,
  input  logic             err_clr,
  output logic [WIDTH-1:0] par_data_out,
  output logic             par_valid,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]  sh_left, sh_right, shifted, start;

  // Both shift directions are formed; MSB_FIRST picks which one the word uses.
  assign sh_left  = {sr_q[WIDTH-2:0], s_in};
  assign sh_right = {s_in, sr_q[WIDTH-1:1]};
  assign shifted  = MSB_FIRST ? sh_left : sh_right;
  assign start    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, s_in} : {s_in, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = err_q & ~err_clr;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sload) begin
          sr_d      = start;
          bit_cnt_d = CntW'(1);
          state_d   = StShift;
        end
      end
      StShift: begin
        if (sload) begin
          // Early marker: drop the partial word and restart; error set beats err_clr.
          err_d     = 1'b1;
          sr_d      = start;
          bit_cnt_d = CntW'(1);
        end else begin
          sr_d      = shifted;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            data_d    = shifted;
            valid_d   = 1'b1;
            cnt_d     = cnt_q + 8'd1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge serclk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign par_data_out = data_q;
  assign par_valid    = valid_q;
  assign busy         = (state_q == StShift);
  assign frame_err    = err_q;
  assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_ser_frame_rx.sv
// Randomised bench for ser_frame_rx: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a bit-queue frame model.
module tb_ser_frame_rx;
  localparam int unsigned W = 8;

  logic serclk = 1'b0;
  logic reset = 1'b1, s_in = 1'b0, sload = 1'b0, err_clr = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic valid_m, valid_l, busy_m, busy_l, err_m, err_l;
  logic [7:0] cnt_m, cnt_l;

  int tests = 0, fails = 0, vcount = 0;
  bit chk_en = 1'b0;

  // Model state: bits of the frame in progress, in arrival order.
  bit q[$];
  logic [W-1:0] e_m = '0, e_l = '0;
  logic e_valid = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [7:0] e_cnt = '0;

  always #5 serclk = ~serclk;

  ser_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .serclk(serclk), .reset(reset), .s_in(s_in), .sload(sload), .err_clr(err_clr),
    .par_data_out(data_m), .par_valid(valid_m), .busy(busy_m), .frame_err(err_m),
    .frame_cnt(cnt_m)
  );

  ser_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .serclk(serclk), .reset(reset), .s_in(s_in), .sload(sload), .err_clr(err_clr),
    .par_data_out(data_l), .par_valid(valid_l), .busy(busy_l), .frame_err(err_l),
    .frame_cnt(cnt_l)
  );

  task automatic model_step();
    if (reset) begin
      q.delete();
      e_m = '0; e_l = '0; e_valid = 1'b0; e_err = 1'b0; e_cnt = '0;
    end else begin
      e_valid = 1'b0;
      if (err_clr) e_err = 1'b0;
      if (sload) begin
        if (q.size() > 0) e_err = 1'b1;
        q.delete();
        q.push_back(s_in);
      end else if (q.size() > 0) begin
        q.push_back(s_in);
      end
      if (q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          e_m[W-1-i] = q[i];
          e_l[i]     = q[i];
        end
        e_valid = 1'b1;
        e_cnt   = e_cnt + 8'd1;
        q.delete();
      end
    end
    e_busy = (q.size() > 0);
  endtask

  initial forever begin
    @(posedge serclk);
    model_step();
  end

  initial forever begin
    @(negedge serclk);
    if (chk_en) begin
      tests++;
      if (data_m !== e_m || data_l !== e_l || valid_m !== e_valid || valid_l !== e_valid ||
          busy_m !== e_busy || busy_l !== e_busy || err_m !== e_err || err_l !== e_err ||
          cnt_m !== e_cnt || cnt_l !== e_cnt) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got data=%h,%h valid=%b%b busy=%b%b err=%b%b cnt=%0d,%0d exp data=%h,%h valid=%b busy=%b err=%b cnt=%0d",
                 $time, data_m, data_l, valid_m, valid_l, busy_m, busy_l, err_m, err_l,
                 cnt_m, cnt_l, e_m, e_l, e_valid, e_busy, e_err, e_cnt);
      end
      if (valid_m === 1'b1) vcount++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input bit sl, input bit b, input bit ec = 1'b0, input bit rs = 1'b0);
    @(posedge serclk);
    #2;
    sload = sl; s_in = b; err_clr = ec; reset = rs;
  endtask

  // Stream is sent word[W-1] first.
  task automatic send_frame(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) drv(i == 0, word[W-1-i]);
  endtask

  initial begin
    drv(0, 0, 0, 1);
    chk_en = 1'b1;
    @(negedge serclk);
    check("rst_data", data_m, 0);
    check("rst_valid", valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_err", err_m, 0);
    check("rst_cnt", cnt_m, 0);
    drv(0, 0);

    send_frame(8'hB2);
    drv(0, 0);
    @(negedge serclk);
    check("b2_msb", data_m, 8'hB2);
    check("b2_lsb", data_l, 8'h4D);
    check("b2_valid", valid_m, 1);
    check("b2_cnt", cnt_m, 1);
    check("b2_err", err_m, 0);
    check("model_b2", e_m, 8'hB2);
    check("model_4d", e_l, 8'h4D);
    drv(0, 0);
    @(negedge serclk);
    check("b2_valid_drop", valid_m, 0);

    send_frame(8'hFF);
    send_frame(8'h00);
    drv(0, 0);
    @(negedge serclk);
    check("b2b_data", data_m, 8'h00);
    check("b2b_cnt", cnt_m, 3);
    check("b2b_err", err_m, 0);

    send_frame(8'hA5);
    drv(0, 0);
    drv(1, 1); drv(0, 0); drv(0, 1); drv(0, 1);
    send_frame(8'h3C);
    @(negedge serclk);
    check("early_hold", data_m, 8'hA5);
    check("early_err", err_m, 1);
    drv(0, 0);
    @(negedge serclk);
    check("early_data", data_m, 8'h3C);
    check("early_cnt", cnt_m, 5);
    drv(0, 0, 1);
    drv(0, 0, 0);
    @(negedge serclk);
    check("err_clr", err_m, 0);

    drv(1, 1);
    drv(1, 0, 1);
    drv(0, 0);
    @(negedge serclk);
    check("set_wins", err_m, 1);

    drv(0, 0, 1);
    drv(1, 1); drv(0, 0); drv(0, 1); drv(0, 1); drv(0, 0);
    drv(1, 1, 0, 1);
    drv(0, 0);
    @(negedge serclk);
    check("midrst_data", data_m, 0);
    check("midrst_busy", busy_m, 0);
    check("midrst_err", err_m, 0);
    check("midrst_cnt", cnt_m, 0);
    send_frame(8'h81);
    drv(0, 0);
    @(negedge serclk);
    check("post_rst_data", data_m, 8'h81);
    check("post_rst_cnt", cnt_m, 1);

    drv(0, 0, 0, 1);
    drv(0, 0);
    vcount = 0;
    for (int f = 0; f < 256; f++) send_frame(W'($urandom));
    drv(0, 0);
    drv(0, 0);
    @(negedge serclk);
    check("wrap_cnt", cnt_m, 0);
    check("wrap_valids", vcount, 256);
    check("wrap_err", err_m, 0);

    for (int c = 0; c < 3000; c++)
      drv($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0);
    drv(0, 0);
    @(negedge serclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
